// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Groups the instruction-memory read port, the redirect input and the
// decoder-side instruction handshake of the fetch unit.
//   master : the fetch unit itself
//   slave  : the environment (instruction memory, branch unit, decoder)
// Signals:
//   mem_r_enable  fetch -> mem   read request
//   mem_addr      fetch -> mem   word-aligned read address
//   mem_data      mem -> fetch   read data, one cycle after the request
//   redirect      env -> fetch   taken branch/jump, one-cycle pulse
//   redirect_pc   env -> fetch   new fetch address (bits [1:0] ignored)
//   instr_valid   fetch -> dec   buffer head holds an instruction
//   instr         fetch -> dec   instruction word at the buffer head
//   instr_pc      fetch -> dec   address of instr
//   instr_ready   dec -> fetch   decoder accepts the head
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        mem_r_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output mem_r_enable, mem_addr, instr_valid, instr, instr_pc,
    input  mem_data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_r_enable, mem_addr, instr_valid, instr, instr_pc,
    output mem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch with a DEPTH-entry instruction buffer and
// credit-based flow control: a read is issued only while the buffer plus the
// single outstanding read leave room, so a response can always be stored.
// A redirect drops the buffer, squashes the read in flight and restarts
// fetching at the new address two cycles later.
// Ports:
//   clk  : clock, all state updates on its rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch_unit_if.master (memory port, redirect, decoder handshake)
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : instruction buffer entries (power of two, >= 2)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_req_pc;
  logic               r_pend;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [31:0]        r_buf_data [DEPTH];
  logic [31:0]        r_buf_pc   [DEPTH];

  logic [CNT_W-1:0]   w_credit;
  logic [CNT_W-1:0]   w_count_next;
  logic [CNT_W-1:0]   w_credit_next;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [31:0]        w_redirect_pc;

  // Credit, handshake and next-occupancy decode
  always_comb begin
    w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    w_credit      = CNT_W'(DEPTH) - r_count - CNT_W'(r_pend);
    w_valid       = (r_count != '0);
    w_pop         = w_valid && bus.instr_ready;
    // The response in flight during a redirect belongs to the old stream.
    w_push        = r_pend && !bus.redirect;
    // Gated by rst so the read strobe is low for the whole reset window.
    w_issue       = rst && (r_state == S_FETCH) && (w_credit != '0) && !bus.redirect;
    if (bus.redirect) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    // Credit as it will stand next cycle decides FETCH versus FULL.
    w_credit_next = CNT_W'(DEPTH) - w_count_next - CNT_W'(w_issue);
  end

  // Fetch state machine, fetch PC, outstanding read and buffer bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0000_0000;
      r_pend     <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (bus.redirect) begin
      r_state    <= S_FLUSH;
      r_fetch_pc <= w_redirect_pc;
      r_pend     <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= (w_credit_next == '0) ? S_FULL : S_FETCH;
        S_FULL:  r_state <= (w_credit_next == '0) ? S_FULL : S_FETCH;
        S_FLUSH: r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
      end
      r_pend   <= w_issue;
      r_count  <= w_count_next;
      // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
    end
  end

  // Buffer storage: response word and its PC written together
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wr_ptr] <= bus.mem_data;
      r_buf_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  // Output drive; head fields read as zero whenever the buffer is empty
  always_comb begin
    bus.mem_r_enable = w_issue;
    bus.mem_addr     = r_fetch_pc;
    bus.instr_valid  = w_valid;
    if (w_valid) begin
      bus.instr    = r_buf_data[r_rd_ptr];
      bus.instr_pc = r_buf_pc[r_rd_ptr];
    end else begin
      bus.instr    = 32'h0000_0000;
      bus.instr_pc = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A memory model answers each read one
// cycle later with an address-tagged word. The reference model is the ideal
// program stream: consecutive word addresses from the last restart point
// (reset or redirect target). The driver keeps an expected-PC queue topped up
// from that stream; a monitor pops it on every decoder handshake.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_pc;
  logic [31:0] exp_req;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  // Memory model: data for a request appears in the following cycle
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
    end else begin
      mem_req_q  <= bus.mem_r_enable;
      mem_addr_q <= bus.mem_addr;
    end
  end
  assign bus.mem_data = mem_req_q ? tag(mem_addr_q) : 32'hDEAD_BEEF;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = {pc[31:2], 2'b00};
    exp_req  = model_pc;
    top_up();
  endtask

  // One cycle: inputs for the new cycle are driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    top_up();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect    = 1'b1;
    bus.redirect_pc = t;
    // The monitor compares this cycle's handshake against the old stream first.
    @(negedge clk);
    #1;
    model_restart(t);
  endtask

  // Monitor / scoreboard, sampling mid-cycle
  initial begin : monitor
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic [31:0] e;
    prev_hold  = 1'b0;
    prev_pc    = 32'h0;
    prev_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check1("hold_valid", bus.instr_valid, 1'b1);
          check32("hold_pc", bus.instr_pc, prev_pc);
          check32("hold_instr", bus.instr, prev_instr);
        end
        if (bus.redirect) check1("no_req_on_redirect", bus.mem_r_enable, 1'b0);
        if (bus.mem_r_enable) begin
          check32("req_addr", bus.mem_addr, exp_req);
          exp_req = exp_req + 32'd4;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got pc %h, expected no delivery", bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            check32("instr_pc", bus.instr_pc, e);
            check32("instr_word", bus.instr, tag(e));
          end
        end
        prev_hold  = bus.instr_valid && !bus.instr_ready && !bus.redirect;
        prev_pc    = bus.instr_pc;
        prev_instr = bus.instr;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int          nreq;
    logic        found;
    logic        saw_top;
    logic        wrapped;
    logic [31:0] t;

    rst             = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    bus.instr_ready = 1'b1;
    model_restart(RST_PC);

    // Reset values, with redirect asserted to confirm it cannot start a read
    repeat (3) step();
    #1;
    check1("rst_mem_r_enable", bus.mem_r_enable, 1'b0);
    check1("rst_instr_valid", bus.instr_valid, 1'b0);
    check32("rst_instr", bus.instr, 32'h0);
    check32("rst_instr_pc", bus.instr_pc, 32'h0);
    bus.redirect = 1'b0;

    // Streaming from reset: latency 2, then one instruction per cycle
    step();
    rst = 1'b1;
    #1;
    check1("first_req_en", bus.mem_r_enable, 1'b1);
    check32("first_req_addr", bus.mem_addr, RST_PC);
    check1("c0_valid", bus.instr_valid, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step();
      #1;
      check1("fill_valid", bus.instr_valid, (k >= 2));
    end

    // Decoder stalled from reset: exactly DEPTH reads, head held
    step(); rst = 1'b0; bus.instr_ready = 1'b0;
    step(); model_restart(RST_PC);
    step(); rst = 1'b1;
    #1;
    nreq = bus.mem_r_enable ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      step();
      #1;
      if (bus.mem_r_enable) nreq++;
    end
    check32("full_req_count", 32'(nreq), 32'(DEPTH));
    check1("full_head_valid", bus.instr_valid, 1'b1);
    check32("full_head_pc", bus.instr_pc, RST_PC);

    // Reset pulse with a full buffer clears outputs at once
    step(); rst = 1'b0;
    #1;
    check1("midrst_mem_r_enable", bus.mem_r_enable, 1'b0);
    check1("midrst_instr_valid", bus.instr_valid, 1'b0);
    check32("midrst_instr", bus.instr, 32'h0);
    check32("midrst_instr_pc", bus.instr_pc, 32'h0);
    step(); model_restart(RST_PC);
    step(); rst = 1'b1;
    #1;
    check1("restart_en", bus.mem_r_enable, 1'b1);
    check32("restart_addr", bus.mem_addr, RST_PC);
    repeat (12) step();
    bus.instr_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      #1;
      if (bus.mem_r_enable) begin
        found = 1'b1;
        check32("resume_addr", bus.mem_addr, RST_PC + 32'(4 * DEPTH));
      end
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL resume_timeout: got no request, expected one within 10 cycles");
    end
    repeat (10) step();

    // Redirect with 3 buffered entries and a read in flight
    step(); rst = 1'b0;
    step(); model_restart(RST_PC);
    step(); rst = 1'b1; bus.instr_ready = 1'b0;
    repeat (3) step();
    step();
    #1;
    check1("pre_redirect_valid", bus.instr_valid, 1'b1);
    redirect_to(32'h0000_0102);
    step(); bus.redirect = 1'b0;
    #1;
    check1("flush_valid", bus.instr_valid, 1'b0);
    check1("flush_req", bus.mem_r_enable, 1'b0);
    step(); bus.instr_ready = 1'b1;
    #1;
    check1("target_req_en", bus.mem_r_enable, 1'b1);
    check32("target_req_addr", bus.mem_addr, 32'h0000_0100);
    check1("target_c6_valid", bus.instr_valid, 1'b0);
    step();
    #1;
    check1("target_c7_valid", bus.instr_valid, 1'b0);
    step();
    #1;
    check1("target_c8_valid", bus.instr_valid, 1'b1);
    check32("target_first_pc", bus.instr_pc, 32'h0000_0100);
    repeat (10) step();

    // Redirect coinciding with a head handshake
    #1;
    check1("hs_redirect_valid", bus.instr_valid, 1'b1);
    redirect_to(32'h0000_2000);
    step(); bus.redirect = 1'b0;
    repeat (12) step();

    // Fetch PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFF4);
    step(); bus.redirect = 1'b0;
    saw_top = 1'b0;
    wrapped = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      #1;
      if (bus.mem_r_enable) begin
        if (saw_top) begin
          check32("wrap_addr", bus.mem_addr, 32'h0000_0000);
          wrapped = 1'b1;
        end
        saw_top = (bus.mem_addr == 32'hFFFF_FFFC);
      end
    end
    check1("wrap_seen", wrapped, 1'b1);

    // Randomized decoder backpressure and redirects
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.redirect    = 1'b0;
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h0000_001F);
        redirect_to(t);
      end
    end

    // Drain: steady stream must be continuous
    step(); bus.redirect = 1'b0; bus.instr_ready = 1'b1;
    repeat (20) step();
    #1;
    check1("drain_valid", bus.instr_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 4, the instruction buffer entries (power of two, >=2).
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port mem_r_enable  output  1  instruction memory read request.
REQ-006 Port mem_addr  output  32  word-aligned read address, valid while mem_r_enable=1.
REQ-007 Port mem_data  input  32  read data, valid exactly one cycle after the request cycle.
REQ-008 Port redirect  input  1  branch/jump taken; one-cycle pulse.
REQ-009 Port redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-010 Port instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 Port instr  output  32  instruction word at buffer head.
REQ-012 Port instr_pc  output  32  address of instr.
REQ-013 Port instr_ready  input  1  decoder accepts head; transfer when instr_valid=1 and instr_ready=1.

Function
REQ-014 State machine SHALL have states FETCH (issuing), FULL (no credit), FLUSH (one cycle after redirect); reset state FETCH.
REQ-015 Credit SHALL be DEPTH minus (buffer count + outstanding request); mem_r_enable SHALL be 1 only in FETCH with credit>0 and redirect=0.
REQ-016 mem_addr SHALL equal fetch_pc; on each issued request fetch_pc SHALL increment by 4, wrapping modulo 2^32.
REQ-017 The PC of each request SHALL be held one cycle and written to the buffer with mem_data in the response cycle unless squashed.
REQ-018 FETCH->FULL when credit becomes 0; FULL->FETCH when credit>0; any state->FLUSH on redirect; FLUSH->FETCH unconditionally.
REQ-019 On redirect: fetch_pc<=redirect_pc with [1:0]=00, buffer count<=0, any in-flight response squashed, no request in that cycle.
REQ-020 In FLUSH, mem_r_enable SHALL be 0 unless redirect is asserted again; first request to the new PC is issued in the cycle after FLUSH (second cycle after redirect).
REQ-021 A head transfer in the redirect cycle SHALL count as delivered; all remaining entries discarded.
REQ-022 instr_valid SHALL be 0 in the cycle after redirect and SHALL not rise before the new-target response is buffered.
REQ-023 Simultaneous push and pop SHALL keep count unchanged; push into a full buffer SHALL never occur (guaranteed by credit).
REQ-024 instr and instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-025 With instr_ready held 1 and no redirect, throughput SHALL be one instruction per cycle after initial fill.
REQ-026 Latency: request in cycle N -> instruction visible at head (instr_valid=1) in cycle N+2 when the buffer was empty.
REQ-027 Buffer read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst=0: mem_r_enable=0, instr_valid=0, instr=0, instr_pc=0, count=0, no outstanding request, fetch_pc=RESET_PC, state FETCH.
REQ-029 Reset assertion mid-operation SHALL take effect immediately (asynchronous) and discard all buffered and in-flight data.
REQ-030 First cycle after rst deasserts: mem_r_enable=1, mem_addr=RESET_PC.

Verification
REQ-031 Reset release, instr_ready=1, memory returns addr-tagged words -> requests at 0,4,8,...; instr_valid from cycle 2; instr_pc 0,4,8 consecutive, one per cycle.
REQ-032 instr_ready=0 from reset -> exactly DEPTH requests (0..12 for DEPTH=4), then mem_r_enable=0, head holds pc 0 stable; raise instr_ready -> fetching resumes at 16, no loss or duplication.
REQ-033 Redirect to 32'h0000_0102 while buffer holds 3 entries and a request in flight -> next cycle instr_valid=0; next request addr 32'h0000_0100; first delivered instr_pc=32'h0000_0100; no stale PCs delivered.
REQ-034 Redirect coinciding with head handshake -> that head delivered once; no other old entries appear.
REQ-035 fetch_pc reaching 32'hFFFF_FFFC -> next request addr 32'h0000_0000.
REQ-036 rst pulsed low mid-stream with full buffer -> outputs zero immediately; after release, fetch restarts at RESET_PC.
